// File: rtl/screen_pkg.sv
// Shared constants and types for the character screen memory write side.
// The display driver's read-side address math uses the same constants.
package screen_pkg;

    localparam int SCREEN_COLS = 40;
    localparam int SCREEN_ROWS = 30;
    localparam int SCREEN_NLOC = SCREEN_ROWS * SCREEN_COLS;
    localparam int SCREEN_AW   = $clog2(SCREEN_NLOC);
    localparam int CHCODE_W    = 4;
    localparam int ROW_W       = 5;
    localparam int COL_W       = 6;

    typedef logic [CHCODE_W-1:0]  chcode_t;
    typedef logic [SCREEN_AW-1:0] saddr_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } sw_state_t;

    localparam saddr_t SADDR_LAST = saddr_t'(SCREEN_NLOC - 1);

endpackage

// File: rtl/screen_addr_calc.sv
// Row-major cell address: row*40 + col, built from shifts and adds so it
// costs no multiplier. Purely combinational.
module screen_addr_calc
    import screen_pkg::*;
(
    input  logic [ROW_W-1:0] row_i,
    input  logic [COL_W-1:0] col_i,
    output saddr_t           addr_o
);

    saddr_t row_w;
    saddr_t col_w;

    assign row_w = saddr_t'(row_i);
    assign col_w = saddr_t'(col_i);

    // 40 = 32 + 8; the largest possible inputs (31, 63) still fit in 11 bits
    assign addr_o = (row_w << 5) + (row_w << 3) + col_w;

endmodule

// File: rtl/screen_writer.sv
// Write-side master for the character screen memory. Turns (row, col, code)
// cell writes into registered write strobes and runs a whole-screen fill sweep.
// Optional build macro SCREEN_WRITER_BOUNDS_CHECK_EN: drops out-of-range writes
// and flags them on a sticky bounds_err output.
//
// state | meaning
// IDLE  | accepting cell writes; a fill_req starts a sweep
// FILL  | writing the latched fill code to addresses 0..NLOC-1, one per cycle
module screen_writer
    import screen_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ROW_W-1:0]    wr_row,
    input  logic [COL_W-1:0]    wr_col,
    input  logic [CHCODE_W-1:0] wr_code,
    input  logic                fill_req,
    input  logic [CHCODE_W-1:0] fill_code,
    output logic                busy,
    output logic                fill_done,
    output logic                smem_wr,
    output logic [SCREEN_AW-1:0] smem_addr,
`ifdef SCREEN_WRITER_BOUNDS_CHECK_EN
    output logic                bounds_err,
`endif
    output logic [CHCODE_W-1:0] smem_wdata
);

    sw_state_t state_q, state_d;
    saddr_t    cnt_q, cnt_d;
    chcode_t   code_q, code_d;
    logic      smem_wr_q, smem_wr_d;
    saddr_t    addr_q, addr_d;
    chcode_t   wdata_q, wdata_d;
    logic      fill_done_q, fill_done_d;
    saddr_t    cell_addr;
    logic      accept;

    screen_addr_calc u_addr_calc (
        .row_i  (wr_row),
        .col_i  (wr_col),
        .addr_o (cell_addr)
    );

    // Fill has priority over a same-cycle cell write; nothing is accepted in reset
    assign wr_ready = (state_q == IDLE) && !fill_req && !reset;
    assign accept   = wr_valid && wr_ready;

`ifdef SCREEN_WRITER_BOUNDS_CHECK_EN
    logic bounds_err_q, bounds_err_d;
    logic in_range;

    assign in_range   = (wr_row < ROW_W'(SCREEN_ROWS)) && (wr_col < COL_W'(SCREEN_COLS));
    assign bounds_err = bounds_err_q;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: leave FILL on the cycle the last address is issued
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fill_req) state_d = FILL;
            FILL: if (cnt_q == SADDR_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; address and data hold when no write is issued
    always_comb begin
        smem_wr_d   = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        fill_done_d = 1'b0;
        cnt_d       = cnt_q;
        code_d      = code_q;
`ifdef SCREEN_WRITER_BOUNDS_CHECK_EN
        bounds_err_d = bounds_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (fill_req) begin
                    code_d = fill_code;
                    cnt_d  = '0;
                end else if (accept) begin
`ifdef SCREEN_WRITER_BOUNDS_CHECK_EN
                    if (in_range) begin
                        smem_wr_d = 1'b1;
                        addr_d    = cell_addr;
                        wdata_d   = wr_code;
                    end else begin
                        bounds_err_d = 1'b1;
                    end
`else
                    smem_wr_d = 1'b1;
                    addr_d    = cell_addr;
                    wdata_d   = wr_code;
`endif
                end
            end
            FILL: begin
                smem_wr_d = 1'b1;
                addr_d    = cnt_q;
                wdata_d   = code_q;
                if (cnt_q == SADDR_LAST) begin
                    fill_done_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any sweep in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            code_q      <= '0;
            smem_wr_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            fill_done_q <= 1'b0;
`ifdef SCREEN_WRITER_BOUNDS_CHECK_EN
            bounds_err_q <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            smem_wr_q   <= smem_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            fill_done_q <= fill_done_d;
`ifdef SCREEN_WRITER_BOUNDS_CHECK_EN
            bounds_err_q <= bounds_err_d;
`endif
        end
    end

    assign busy       = (state_q == FILL);
    assign fill_done  = fill_done_q;
    assign smem_wr    = smem_wr_q;
    assign smem_addr  = addr_q;
    assign smem_wdata = wdata_q;

endmodule
